// File: rtl/lut_ptr_pkg.sv
// Shared types and helpers for the lut_ptr pointer table.
//   upd_dir_t      : post-update direction (increment / decrement)
//   INIT_VALS_DFLT : default packed reset values for the 4 x 8-bit build
//   step()         : modular add/subtract of a stride, returns {wrap, new}
package lut_ptr_pkg;

  typedef enum logic {
    UPD_INC = 1'b0,
    UPD_DEC = 1'b1
  } upd_dir_t;

  // Entry 0 sits in the LSBs.
  localparam logic [31:0] INIT_VALS_DFLT = {8'd255, 8'd5, 8'd4, 8'd3};

  // Widest address the step helper handles.
  localparam int unsigned STEP_W = 32;

  // Steps 'old' by 'stride' modulo 2**width. 'old' and 'stride' must already
  // fit in 'width' bits. Bit STEP_W of the result is the wrap flag.
  function automatic logic [STEP_W:0] step(input logic [STEP_W-1:0] old,
                                           input upd_dir_t          dir,
                                           input logic [STEP_W-1:0] stride,
                                           input int unsigned       width);
    logic [STEP_W-1:0] mask;
    logic [STEP_W-1:0] nxt;
    logic              wrap;
    mask = (width >= STEP_W) ? '1 : ((32'd1 << width) - 32'd1);
    if (dir == UPD_INC) begin
      nxt  = (old + stride) & mask;
      wrap = (nxt < old);
    end else begin
      nxt  = (old - stride) & mask;
      wrap = (nxt > old);
    end
    return {wrap, nxt};
  endfunction

endpackage

// File: rtl/lut_ptr_entry.sv
// One pointer register of the lut_ptr table.
//   clk_i, reset_i : clock, asynchronous active-high reset to RST_VAL
//   ld_en_i        : load ld_data_i (has priority over a step)
//   step_en_i      : step by STRIDE in direction step_dir_i
//   val_o          : current register value
//   wrap_o         : the step that would be taken now wraps (combinational)
module lut_ptr_entry
  import lut_ptr_pkg::*;
#(
  parameter int unsigned        ADDR_W  = 8,
  parameter int unsigned        STRIDE  = 1,
  parameter logic [ADDR_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_data_i,
  input  logic              step_en_i,
  input  upd_dir_t          step_dir_i,
  output logic [ADDR_W-1:0] val_o,
  output logic              wrap_o
);

  logic [ADDR_W-1:0] val_q, val_d;
  logic [STEP_W:0]   step_res;
  logic              unused_step;

  always_comb begin
    step_res = step(STEP_W'(val_q), step_dir_i, STEP_W'(STRIDE), ADDR_W);
    val_d    = val_q;
    if (ld_en_i) begin
      val_d = ld_data_i;
    end else if (step_en_i) begin
      val_d = step_res[ADDR_W-1:0];
    end
  end

  // Upper bits of the helper result are zero by construction.
  assign unused_step = ^step_res;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      val_q <= RST_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o  = val_q;
  assign wrap_o = step_res[STEP_W];

endmodule

// File: rtl/lut_ptr.sv
// Writable pointer table producing data-memory addresses from a selector.
//   clk, reset : clock, asynchronous active-high reset to INIT_VALS
//   ptr        : selects the entry for the current access
//   dm_adr     : entry[ptr] (pre-update), all-ones when ptr >= DEPTH
//   upd_en     : post-update entry[ptr] by STRIDE; upd_dir 0 = add, 1 = sub
//   wr_en      : load wr_data into entry[wr_ptr]; wins over an update
//   wrapped    : registered pulse, previous edge's update wrapped
module lut_ptr
  import lut_ptr_pkg::*;
#(
  parameter int unsigned               PTR_W     = 2,
  parameter int unsigned               DEPTH     = 4,
  parameter int unsigned               ADDR_W    = 8,
  parameter int unsigned               STRIDE    = 1,
  parameter logic [DEPTH*ADDR_W-1:0]   INIT_VALS = (DEPTH*ADDR_W)'(INIT_VALS_DFLT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PTR_W-1:0]  ptr,
  output logic [ADDR_W-1:0] dm_adr,
  input  logic              upd_en,
  input  logic              upd_dir,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [ADDR_W-1:0] wr_data,
  output logic              wrapped
);

  logic [ADDR_W-1:0] ent_val [DEPTH];
  logic [DEPTH-1:0]  ld_en;
  logic [DEPTH-1:0]  step_en;
  logic [DEPTH-1:0]  step_wrap;
  logic              wrapped_q, wrapped_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    lut_ptr_entry #(
      .ADDR_W  (ADDR_W),
      .STRIDE  (STRIDE),
      .RST_VAL (INIT_VALS[g*ADDR_W +: ADDR_W])
    ) u_entry (
      .clk_i      (clk),
      .reset_i    (reset),
      .ld_en_i    (ld_en[g]),
      .ld_data_i  (wr_data),
      .step_en_i  (step_en[g]),
      .step_dir_i (upd_dir_t'(upd_dir)),
      .val_o      (ent_val[g]),
      .wrap_o     (step_wrap[g])
    );
  end

  // Selectors beyond DEPTH match no entry, so they read all-ones and never
  // load or step anything.
  always_comb begin
    ld_en   = '0;
    step_en = '0;
    dm_adr  = '1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ld_en[i]   = wr_en && (wr_ptr == PTR_W'(i));
      step_en[i] = upd_en && (ptr == PTR_W'(i)) && !ld_en[i];
      if (ptr == PTR_W'(i)) begin
        dm_adr = ent_val[i];
      end
    end
    // Only a step that is actually taken may flag a wrap.
    wrapped_d = |(step_en & step_wrap);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrapped_q <= 1'b0;
    end else begin
      wrapped_q <= wrapped_d;
    end
  end

  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_lut_ptr.sv
// Scoreboard bench for lut_ptr. Four builds share clk/reset:
//   0: default (4 x 8-bit, stride 1)   1: DEPTH = 3
//   2: STRIDE = 4                      3: PTR_W = 3, DEPTH = 8, ADDR_W = 10
// Stimulus pushes expected values tagged with the cycle they apply to; the
// monitor pops and compares on every falling edge.
module tb_lut_ptr;

  typedef struct {
    int    cyc;
    int    dut;
    bit    is_wrap;
    int    exp;
    string name;
  } exp_t;

  logic clk, reset;
  int   cyc;
  exp_t sb[$];
  int   n_vec, n_err;

  logic [1:0] ptr_a, wp_a, ptr_b, wp_b, ptr_c, wp_c;
  logic [2:0] ptr_d, wp_d;
  logic [7:0] wd_a, wd_b, wd_c, adr_a, adr_b, adr_c;
  logic [9:0] wd_d, adr_d;
  logic       ue_a, ud_a, we_a, wr_a_o;
  logic       ue_b, ud_b, we_b, wr_b_o;
  logic       ue_c, ud_c, we_c, wr_c_o;
  logic       ue_d, ud_d, we_d, wr_d_o;

  int obs_adr [4];
  int obs_wrap[4];

  lut_ptr u_a (
    .clk(clk), .reset(reset), .ptr(ptr_a), .dm_adr(adr_a), .upd_en(ue_a), .upd_dir(ud_a),
    .wr_en(we_a), .wr_ptr(wp_a), .wr_data(wd_a), .wrapped(wr_a_o)
  );

  lut_ptr #(.DEPTH(3), .INIT_VALS(24'h05_04_03)) u_b (
    .clk(clk), .reset(reset), .ptr(ptr_b), .dm_adr(adr_b), .upd_en(ue_b), .upd_dir(ud_b),
    .wr_en(we_b), .wr_ptr(wp_b), .wr_data(wd_b), .wrapped(wr_b_o)
  );

  lut_ptr #(.STRIDE(4)) u_c (
    .clk(clk), .reset(reset), .ptr(ptr_c), .dm_adr(adr_c), .upd_en(ue_c), .upd_dir(ud_c),
    .wr_en(we_c), .wr_ptr(wp_c), .wr_data(wd_c), .wrapped(wr_c_o)
  );

  lut_ptr #(
    .PTR_W(3), .DEPTH(8), .ADDR_W(10),
    .INIT_VALS({10'd1023, 10'd63, 10'd53, 10'd43, 10'd33, 10'd23, 10'd13, 10'd3})
  ) u_d (
    .clk(clk), .reset(reset), .ptr(ptr_d), .dm_adr(adr_d), .upd_en(ue_d), .upd_dir(ud_d),
    .wr_en(we_d), .wr_ptr(wp_d), .wr_data(wd_d), .wrapped(wr_d_o)
  );

  always_comb begin
    obs_adr[0]  = int'(adr_a);
    obs_adr[1]  = int'(adr_b);
    obs_adr[2]  = int'(adr_c);
    obs_adr[3]  = int'(adr_d);
    obs_wrap[0] = int'(wr_a_o);
    obs_wrap[1] = int'(wr_b_o);
    obs_wrap[2] = int'(wr_c_o);
    obs_wrap[3] = int'(wr_d_o);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has come.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e     = sb.pop_front();
        act   = e.is_wrap ? obs_wrap[e.dut] : obs_adr[e.dut];
        n_vec = n_vec + 1;
        if (e.cyc != cyc || act != e.exp) begin
          n_err = n_err + 1;
          $display("FAIL %s (dut %0d, cycle %0d): got %0d, expected %0d",
                   e.name, e.dut, cyc, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input int d, input int v, input string n);
    exp_t e;
    e = '{cyc: cyc, dut: d, is_wrap: 1'b0, exp: v, name: n};
    sb.push_back(e);
  endtask

  task automatic chk_w(input int d, input int v, input string n);
    exp_t e;
    e = '{cyc: cyc, dut: d, is_wrap: 1'b1, exp: v, name: n};
    sb.push_back(e);
  endtask

  task automatic drv(input int d, input int p, input bit u, input bit dir,
                     input bit w, input int wp, input int wdat);
    case (d)
      0: begin ptr_a = 2'(p); ue_a = u; ud_a = dir; we_a = w; wp_a = 2'(wp); wd_a = 8'(wdat); end
      1: begin ptr_b = 2'(p); ue_b = u; ud_b = dir; we_b = w; wp_b = 2'(wp); wd_b = 8'(wdat); end
      2: begin ptr_c = 2'(p); ue_c = u; ud_c = dir; we_c = w; wp_c = 2'(wp); wd_c = 8'(wdat); end
      default: begin
        ptr_d = 3'(p); ue_d = u; ud_d = dir; we_d = w; wp_d = 3'(wp); wd_d = 10'(wdat);
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int d = 0; d < 4; d++) drv(d, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // 1: reset values, then a reset pulse with no clock edge
    drv(0, 0, 1, 0, 0, 0, 0); chk_a(0, 3, "rst_e0"); chk_w(0, 0, "rst_wrap");
    tick();
    drv(0, 0, 0, 0, 0, 0, 0); chk_a(0, 4, "pre_pulse_e0");
    tick();
    drv(1, 3, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    if (adr_a !== 8'd3) begin
      n_err = n_err + 1;
      $display("FAIL pulse_direct_e0: got %0d, expected 3", adr_a);
    end
    if (adr_b !== 8'd255) begin
      n_err = n_err + 1;
      $display("FAIL pulse_direct_b_oor: got %0d, expected 255", adr_b);
    end
    if (wr_a_o !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL pulse_direct_wrap: got %0d, expected 0", wr_a_o);
    end
    chk_a(0, 3, "pulse_e0"); chk_w(0, 0, "pulse_wrap"); chk_a(1, 255, "b_oor_rd");
    tick(); drv(0, 1, 0, 0, 0, 0, 0); chk_a(0, 4, "rst_e1"); drv(1, 2, 0, 0, 0, 0, 0);
    chk_a(1, 5, "b_rst_e2");
    tick(); drv(0, 2, 0, 0, 0, 0, 0); chk_a(0, 5, "rst_e2");
    tick(); drv(0, 3, 0, 0, 0, 0, 0); chk_a(0, 255, "rst_e3");

    // 2: post-increment entry 0
    tick(); drv(0, 0, 1, 0, 0, 0, 0); chk_a(0, 3, "inc0"); chk_w(0, 0, "inc_w0");
    tick(); chk_a(0, 4, "inc1"); chk_w(0, 0, "inc_w1");
    tick(); chk_a(0, 5, "inc2"); chk_w(0, 0, "inc_w2");
    tick(); drv(0, 0, 0, 0, 0, 0, 0); chk_a(0, 6, "inc3"); chk_w(0, 0, "inc_w3");
    tick(); drv(0, 1, 0, 0, 0, 0, 0); chk_a(0, 4, "inc_e1_kept");
    tick(); drv(0, 3, 0, 0, 0, 0, 0); chk_a(0, 255, "inc_e3_kept");

    // 3: wrap on increment and decrement
    tick(); drv(0, 2, 0, 0, 1, 2, 254); chk_a(0, 5, "wr_old_e2");
    tick(); drv(0, 2, 1, 0, 0, 0, 0); chk_a(0, 254, "wr_e2"); chk_w(0, 0, "wi_w0");
    tick(); chk_a(0, 255, "wi_255"); chk_w(0, 0, "wi_w1");
    tick(); drv(0, 2, 0, 0, 0, 0, 0); chk_a(0, 0, "wi_0"); chk_w(0, 1, "wi_pulse");
    tick(); chk_a(0, 0, "wi_hold"); chk_w(0, 0, "wi_pulse_end");
    tick(); drv(0, 1, 0, 0, 1, 1, 0); chk_a(0, 4, "wd_old_e1");
    tick(); drv(0, 1, 1, 1, 0, 0, 0); chk_a(0, 0, "wd_e1"); chk_w(0, 0, "wd_w0");
    tick(); drv(0, 1, 0, 0, 0, 0, 0); chk_a(0, 255, "wd_255"); chk_w(0, 1, "wd_pulse");
    tick(); chk_w(0, 0, "wd_pulse_end");
    // stride 4 build
    tick(); drv(2, 0, 0, 0, 1, 0, 253); chk_a(2, 3, "s4_old");
    tick(); drv(2, 0, 1, 0, 0, 0, 0); chk_a(2, 253, "s4_wr"); chk_w(2, 0, "s4_w0");
    tick(); drv(2, 0, 1, 1, 0, 0, 0); chk_a(2, 1, "s4_inc"); chk_w(2, 1, "s4_inc_wrap");
    tick(); drv(2, 0, 0, 0, 0, 0, 0); chk_a(2, 253, "s4_dec"); chk_w(2, 1, "s4_dec_wrap");
    tick(); chk_w(2, 0, "s4_w_end");

    // 4: write/update collisions
    tick(); drv(0, 0, 1, 0, 1, 0, 100); chk_a(0, 6, "col_old");
    tick(); drv(0, 0, 0, 0, 0, 0, 0); chk_a(0, 100, "col_same"); chk_w(0, 0, "col_same_w");
    tick(); drv(0, 1, 1, 0, 1, 0, 77); chk_a(0, 255, "col2_old_e1");
    tick(); drv(0, 1, 0, 0, 0, 0, 0); chk_a(0, 0, "col2_e1"); chk_w(0, 1, "col2_wrap");
    tick(); drv(0, 0, 0, 0, 0, 0, 0); chk_a(0, 77, "col2_e0"); chk_w(0, 0, "col2_w_end");
    // dropped decrement of 0 would have wrapped
    tick(); drv(0, 1, 1, 1, 1, 1, 9); chk_a(0, 0, "col3_old");
    tick(); drv(0, 1, 0, 0, 0, 0, 0); chk_a(0, 9, "col3_e1"); chk_w(0, 0, "col3_no_wrap");

    // 5: reset in the middle of an update run
    tick(); drv(0, 0, 0, 0, 1, 0, 50); chk_a(0, 77, "r5_old");
    tick(); drv(0, 0, 1, 0, 0, 0, 0); chk_a(0, 50, "r5_50");
    tick(); chk_a(0, 51, "r5_51");
    tick();
    #1 reset = 1'b1;
    #1;
    if (adr_a !== 8'd3) begin
      n_err = n_err + 1;
      $display("FAIL r5_direct: got %0d, expected 3", adr_a);
    end
    chk_a(0, 3, "r5_async"); chk_w(0, 0, "r5_w");
    tick(); chk_a(0, 3, "r5_held");
    tick(); reset = 1'b0; chk_a(0, 3, "r5_release");
    tick(); chk_a(0, 4, "r5_resume");
    tick(); drv(0, 0, 0, 0, 0, 0, 0); chk_a(0, 5, "r5_resume2");
    tick(); chk_a(0, 5, "r5_stop");

    // 6: out-of-range update and write on the DEPTH = 3 build
    tick(); drv(1, 3, 1, 0, 1, 3, 17); chk_a(1, 255, "oor_rd"); chk_w(1, 0, "oor_w0");
    tick(); drv(1, 3, 1, 1, 0, 0, 0); chk_a(1, 255, "oor_rd2"); chk_w(1, 0, "oor_w1");
    tick(); drv(1, 0, 0, 0, 0, 0, 0); chk_a(1, 3, "oor_e0"); chk_w(1, 0, "oor_w2");
    tick(); drv(1, 1, 0, 0, 0, 0, 0); chk_a(1, 4, "oor_e1");
    tick(); drv(1, 2, 0, 0, 0, 0, 0); chk_a(1, 5, "oor_e2");

    // PTR_W = 3, DEPTH = 8, ADDR_W = 10 build
    tick(); drv(3, 0, 1, 0, 0, 0, 0); chk_a(3, 3, "d_inc0"); chk_w(3, 0, "d_w0");
    tick(); chk_a(3, 4, "d_inc1");
    tick(); chk_a(3, 5, "d_inc2");
    tick(); drv(3, 0, 0, 0, 0, 0, 0); chk_a(3, 6, "d_inc3"); chk_w(3, 0, "d_w3");
    tick(); drv(3, 4, 0, 0, 0, 0, 0); chk_a(3, 43, "d_e4_kept");
    tick(); drv(3, 7, 1, 0, 0, 0, 0); chk_a(3, 1023, "d_e7"); chk_w(3, 0, "d_w7");
    tick(); drv(3, 7, 0, 0, 0, 0, 0); chk_a(3, 0, "d_e7_wrap"); chk_w(3, 1, "d_pulse7");
    tick(); chk_w(3, 0, "d_pulse7_end");
    tick(); drv(3, 5, 0, 0, 1, 5, 1022); chk_a(3, 53, "d_old_e5");
    tick(); drv(3, 5, 1, 0, 0, 0, 0); chk_a(3, 1022, "d_wr_e5"); chk_w(3, 0, "d_w5a");
    tick(); chk_a(3, 1023, "d_e5_1023"); chk_w(3, 0, "d_w5b");
    tick(); drv(3, 5, 0, 0, 0, 0, 0); chk_a(3, 0, "d_e5_0"); chk_w(3, 1, "d_pulse5");
    tick(); chk_a(3, 0, "d_e5_hold"); chk_w(3, 0, "d_pulse5_end");
    tick(); drv(3, 6, 0, 0, 1, 6, 0); chk_a(3, 63, "d_old_e6");
    tick(); drv(3, 6, 1, 1, 0, 0, 0); chk_a(3, 0, "d_wr_e6");
    tick(); drv(3, 6, 0, 0, 0, 0, 0); chk_a(3, 1023, "d_dec_e6"); chk_w(3, 1, "d_pulse6");
    tick(); chk_w(3, 0, "d_pulse6_end");

    tick();
    tick();
    while (sb.size() > 0) begin
      exp_t e;
      e     = sb.pop_front();
      n_err = n_err + 1;
      $display("FAIL %s: got no sample, expected %0d", e.name, e.exp);
    end
    if (n_vec == 0) begin
      n_err = n_err + 1;
      $display("FAIL monitor: got 0 vectors, expected at least 1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
